// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: fetch FSM states and pipeline constants.
package core_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PARK  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    // addi x0,x0,0 -- also used by decode to recognise bubbles
    localparam logic [31:0] NOP_INS      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Bubble has priority over hold, hold over load.
module ifid_reg #(
    parameter logic [31:0] NOP_INS = core_pkg::NOP_INS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        hold,
    input  logic        bubble,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_ins,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_ins,
    output logic        ifid_valid
);

    // register update: bubble clears, hold keeps, load captures the fetched word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_pc    <= 32'd0;
            ifid_ins   <= NOP_INS;
            ifid_valid <= 1'b0;
        end else if (bubble) begin
            ifid_pc    <= 32'd0;
            ifid_ins   <= NOP_INS;
            ifid_valid <= 1'b0;
        end else if (hold) begin
            ifid_pc    <= ifid_pc;
            ifid_ins   <= ifid_ins;
            ifid_valid <= ifid_valid;
        end else if (load) begin
            ifid_pc    <= fetch_pc;
            ifid_ins   <= fetch_ins;
            ifid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux and sequencing FSM.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_BOOT  | one cycle after reset, PC at reset value, IF/ID bubbled
//   ST_RUN   | fetching; redirect > out-of-range > stall > normal
//   ST_PARK  | PC past end of image, bubbles until an older jump redirects
//   ST_FAULT | misaligned redirect seen, everything frozen until reset
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = core_pkg::RESET_PC_DEF,
    parameter logic [31:0] IMEM_BYTES = 32'd48,
    parameter logic [31:0] NOP_INS    = core_pkg::NOP_INS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_ins,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_ins,
    output logic        ifid_valid,
    output logic        idle,
    output logic        fault
);

    import core_pkg::*;

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic         ifid_load;
    logic         ifid_hold;
    logic         ifid_bubble;

    // state and PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // next state, next PC and IF/ID control
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        ifid_load   = 1'b0;
        ifid_hold   = 1'b0;
        ifid_bubble = 1'b0;
        unique case (state)
            ST_BOOT: begin
                ifid_bubble = 1'b1;
                state_next  = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    // a redirect bubbles IF/ID even under stall
                    ifid_bubble = 1'b1;
                    if (word_aligned(redirect_pc)) begin
                        pc_next = redirect_pc;
                    end else begin
                        state_next = ST_FAULT;
                    end
                end else if (pc >= IMEM_BYTES) begin
                    ifid_bubble = 1'b1;
                    state_next  = ST_PARK;
                end else if (stall) begin
                    ifid_hold   = 1'b1;
                    ifid_bubble = flush;
                end else begin
                    ifid_load   = 1'b1;
                    ifid_bubble = flush;
                    pc_next     = pc + 32'd4;
                end
            end
            ST_PARK: begin
                ifid_bubble = 1'b1;
                if (redirect) begin
                    if (word_aligned(redirect_pc)) begin
                        pc_next    = redirect_pc;
                        state_next = ST_RUN;
                    end else begin
                        state_next = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                ifid_bubble = 1'b1;
            end
            default: begin
                ifid_bubble = 1'b1;
                state_next  = ST_FAULT;
            end
        endcase
    end

    assign imem_addr = pc;
    assign idle      = (state == ST_PARK);
    assign fault     = (state == ST_FAULT);

    ifid_reg #(
        .NOP_INS(NOP_INS)
    ) u_ifid_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (ifid_load),
        .hold      (ifid_hold),
        .bubble    (ifid_bubble),
        .fetch_pc  (pc),
        .fetch_ins (imem_ins),
        .ifid_pc   (ifid_pc),
        .ifid_ins  (ifid_ins),
        .ifid_valid(ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a driver steps a behavioural model and
// queues the expected post-edge outputs; a monitor pops and compares them.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int unsigned IMEM = 48;

    localparam int M_BOOT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PARK  = 2;
    localparam int M_FAULT = 3;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        valid;
        logic        idle;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_ins;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_ins;
    logic        ifid_valid;
    logic        idle;
    logic        fault;

    logic [31:0] mem [64];
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    logic [31:0] m_ins;
    logic        m_valid;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a < 32'd256) return mem[a[7:2]];
        return 32'hFFFF_FFFF;
    endfunction

    assign imem_ins = word_at(imem_addr);

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_ins   (imem_ins),
        .ifid_pc    (ifid_pc),
        .ifid_ins   (ifid_ins),
        .ifid_valid (ifid_valid),
        .idle       (idle),
        .fault      (fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    task automatic model_bubble();
        m_ipc   = 32'd0;
        m_ins   = NOP;
        m_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_mode = M_BOOT;
        m_pc   = 32'd0;
        model_bubble();
    endtask

    function automatic exp_t model_view();
        exp_t e;
        e.addr  = m_pc;
        e.pc    = m_ipc;
        e.ins   = m_ins;
        e.valid = m_valid;
        e.idle  = (m_mode == M_PARK);
        e.fault = (m_mode == M_FAULT);
        return e;
    endfunction

    // one clock of fetch behaviour, expressed directly as the stage's rules
    task automatic model_step(input bit rd, input logic [31:0] rpc, input bit st, input bit fl);
        bit aligned;
        aligned = (rpc % 4) == 0;
        if (m_mode == M_BOOT) begin
            model_bubble();
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (rd) begin
                model_bubble();
                if (aligned) m_pc = rpc;
                else m_mode = M_FAULT;
            end else if (m_pc >= IMEM) begin
                model_bubble();
                m_mode = M_PARK;
            end else if (st) begin
                if (fl) model_bubble();
            end else begin
                if (fl) model_bubble();
                else begin
                    m_ipc   = m_pc;
                    m_ins   = word_at(m_pc);
                    m_valid = 1'b1;
                end
                m_pc = m_pc + 32'd4;
            end
        end else if (m_mode == M_PARK) begin
            model_bubble();
            if (rd) begin
                if (aligned) begin
                    m_pc   = rpc;
                    m_mode = M_RUN;
                end else begin
                    m_mode = M_FAULT;
                end
            end
        end else begin
            model_bubble();
        end
    endtask

    // called at a falling edge: apply inputs for the next rising edge
    task automatic drive(input bit rd, input logic [31:0] rpc, input bit st, input bit fl);
        redirect    = rd;
        redirect_pc = rpc;
        stall       = st;
        flush       = fl;
        model_step(rd, rpc, st, fl);
        sb.push_back(model_view());
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_imem_addr"}, imem_addr, 32'd0);
        chk({tag, "_ifid_pc"}, ifid_pc, 32'd0);
        chk({tag, "_ifid_ins"}, ifid_ins, NOP);
        chk({tag, "_ifid_valid"}, {31'd0, ifid_valid}, 32'd0);
        chk({tag, "_idle"}, {31'd0, idle}, 32'd0);
        chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    endtask

    // called at a falling edge: assert reset between edges, check, release one cycle later
    task automatic async_reset(input string tag);
        redirect = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_values(tag);
        model_reset();
        sb.push_back(model_view());
        @(negedge clk);
        rst = 1'b0;
    endtask

    // monitor: compare every post-edge output against the oldest expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("imem_addr", imem_addr, e.addr);
            chk("ifid_pc", ifid_pc, e.pc);
            chk("ifid_ins", ifid_ins, e.ins);
            chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
            chk("idle", {31'd0, idle}, {31'd0, e.idle});
            chk("fault", {31'd0, fault}, {31'd0, e.fault});
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0293;
        mem[1] = 32'h0000_0313;

        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        #1 check_reset_values("por");
        model_reset();
        sb.push_back(model_view());
        @(negedge clk);
        rst = 1'b0;

        // reset then run: boot bubble, then words 0 and 4
        repeat (3) drive(0, 0, 0, 0);
        // 3-cycle stall at pc=8, then resume
        repeat (3) drive(0, 0, 1, 0);
        repeat (2) drive(0, 0, 0, 0);
        // stall with flush
        drive(0, 0, 1, 1);
        drive(0, 0, 0, 1);
        // redirect under stall
        drive(1, 32'h18, 1, 0);
        repeat (7) drive(0, 0, 0, 0);
        // parked past the end, stall ignored
        repeat (3) drive(0, 0, 1, 0);
        drive(1, 32'h14, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        // misaligned redirect
        drive(1, 32'h1A, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        drive(1, 32'h10, 0, 0);
        async_reset("after_fault");
        // run to pc=0x20 then reset mid-cycle
        repeat (9) drive(0, 0, 0, 0);
        async_reset("mid_run");
        repeat (3) drive(0, 0, 0, 0);
        // redirect to out-of-range target: parks the following cycle
        drive(1, 32'h38, 0, 0);
        repeat (2) drive(0, 0, 0, 0);
        drive(1, 32'h2C, 0, 0);
        repeat (3) drive(0, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            bit          rd;
            bit          st;
            bit          fl;
            logic [31:0] rpc;
            rd  = ($urandom_range(0, 7) == 0);
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 5) == 0);
            rpc = 32'($urandom_range(0, 15)) * 32'd4;
            if ($urandom_range(0, 24) == 0) rpc = rpc + 32'($urandom_range(1, 3));
            if ((m_mode == M_FAULT && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
                async_reset("rand");
            else
                drive(rd, rpc, st, fl);
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
